// File: rtl/rv_core_pkg.sv
// -----------------------------------------------------------------------------
// rv_core_pkg
// Shared constants and types for the RV32I core integer register file.
//   XLEN     : data width
//   NREGS    : architectural register count (x0..x31)
//   AW       : register index width
//   REG_ZERO : index of the hardwired-zero register
//   rf_state_t : register-file sequencing states (clear sweep, normal run)
// -----------------------------------------------------------------------------
package rv_core_pkg;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int AW    = 5;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef enum logic {
    RF_CLEAR,
    RF_RUN
  } rf_state_t;

endpackage

// File: rtl/rf_read_port.sv
// -----------------------------------------------------------------------------
// rf_read_port
// Value selection for one register-file read port, in priority order:
// index 0 reads zero, then a same-cycle writeback to the same index is
// forwarded, otherwise the stored word is returned.
// Ports:
//   rs_addr  : source register index for this port
//   wr_en    : accepted writeback strobe this cycle
//   rd_addr  : writeback destination index
//   wr_data  : writeback value
//   mem_data : stored word at rs_addr
//   rs_value : selected value, registered by the parent
// -----------------------------------------------------------------------------
module rf_read_port
  import rv_core_pkg::*;
#(
  parameter int PXLEN = 32,
  parameter int PAW   = 5
) (
  input  logic [PAW-1:0]   rs_addr,
  input  logic             wr_en,
  input  logic [PAW-1:0]   rd_addr,
  input  logic [PXLEN-1:0] wr_data,
  input  logic [PXLEN-1:0] mem_data,
  output logic [PXLEN-1:0] rs_value
);

  always_comb begin
    rs_value = mem_data;
    if (rs_addr == PAW'(REG_ZERO)) begin
      rs_value = '0;
    end else if (wr_en && (rd_addr == rs_addr)) begin
      // rs_addr is non-zero here, so rd_addr is too
      rs_value = wr_data;
    end
  end

endmodule

// File: rtl/reg_file.sv
// -----------------------------------------------------------------------------
// reg_file
// RV32I architectural integer register file: two registered read ports, one
// writeback port, same-cycle write-to-read bypass, x0 hardwired to zero.
// After reset a sweep zeroes x1..x31 before any access is accepted.
// Ports:
//   clk               : core clock, rising edge
//   rst               : asynchronous active-high reset
//   ready             : clear sweep complete; accesses accepted only when high
//   rd_en             : read request for rs1_addr/rs2_addr
//   rs1_addr/rs2_addr : source indices
//   rs1_data/rs2_data : registered read values
//   rd_valid          : outputs hold the previous cycle's accepted read
//   wr_en/rd_addr/wr_data : writeback port
// -----------------------------------------------------------------------------
module reg_file
  import rv_core_pkg::*;
#(
  parameter int XLEN  = rv_core_pkg::XLEN,
  parameter int NREGS = rv_core_pkg::NREGS,
  parameter int AW    = rv_core_pkg::AW
) (
  input  logic            clk,
  input  logic            rst,
  output logic            ready,
  input  logic            rd_en,
  input  logic [AW-1:0]   rs1_addr,
  input  logic [AW-1:0]   rs2_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  output logic            rd_valid,
  input  logic            wr_en,
  input  logic [AW-1:0]   rd_addr,
  input  logic [XLEN-1:0] wr_data
);

  localparam logic [AW-1:0] LAST_REG = AW'(NREGS - 1);

  // x0 is never stored
  logic [XLEN-1:0] mem [1:NREGS-1];

  rf_state_t     state_reg, state_next;
  logic [AW-1:0] clr_ptr_reg, clr_ptr_next;

  logic clr_we;
  logic wr_accept;
  logic rd_accept;

  logic            mem_we;
  logic [AW-1:0]   mem_waddr;
  logic [XLEN-1:0] mem_wdata;

  logic [AW-1:0]   port_addr  [2];
  logic [XLEN-1:0] port_mem   [2];
  logic [XLEN-1:0] port_value [2];

  logic [XLEN-1:0] rs1_data_reg, rs2_data_reg;
  logic            rd_valid_reg;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= RF_CLEAR;
      clr_ptr_reg <= AW'(1);
    end else begin
      state_reg   <= state_next;
      clr_ptr_reg <= clr_ptr_next;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_next   = state_reg;
    clr_ptr_next = clr_ptr_reg;
    if (state_reg == RF_CLEAR) begin
      clr_ptr_next = clr_ptr_reg + AW'(1);
      if (clr_ptr_reg == LAST_REG) begin
        state_next   = RF_RUN;
        clr_ptr_next = AW'(1);
      end
    end
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    ready     = 1'b0;
    clr_we    = 1'b0;
    wr_accept = 1'b0;
    rd_accept = 1'b0;
    if (state_reg == RF_CLEAR) begin
      clr_we = 1'b1;
    end else begin
      ready     = 1'b1;
      wr_accept = wr_en && (rd_addr != AW'(REG_ZERO));
      rd_accept = rd_en;
    end
  end

  // Single write port shared by the sweep and writeback
  always_comb begin
    mem_we    = clr_we | wr_accept;
    mem_waddr = clr_we ? clr_ptr_reg : rd_addr;
    mem_wdata = clr_we ? '0 : wr_data;
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  // ---------------- read ports ----------------
  assign port_addr[0] = rs1_addr;
  assign port_addr[1] = rs2_addr;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_rd_port
      // Index 0 is outside the storage range; the port forces it to zero anyway
      assign port_mem[gi] = (port_addr[gi] == AW'(REG_ZERO)) ? '0 : mem[port_addr[gi]];

      rf_read_port #(
        .PXLEN(XLEN),
        .PAW  (AW)
      ) u_port (
        .rs_addr (port_addr[gi]),
        .wr_en   (wr_accept),
        .rd_addr (rd_addr),
        .wr_data (wr_data),
        .mem_data(port_mem[gi]),
        .rs_value(port_value[gi])
      );
    end
  endgenerate

  // ---------------- output registers ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rs1_data_reg <= '0;
      rs2_data_reg <= '0;
      rd_valid_reg <= 1'b0;
    end else begin
      rd_valid_reg <= rd_accept;
      if (rd_accept) begin
        rs1_data_reg <= port_value[0];
        rs2_data_reg <= port_value[1];
      end
    end
  end

  assign rs1_data = rs1_data_reg;
  assign rs2_data = rs2_data_reg;
  assign rd_valid = rd_valid_reg;

endmodule

// File: tb/tb_reg_file.sv
module tb_reg_file;

  logic        clk;
  logic        rst;
  logic        ready;
  logic        rd_en;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        rd_valid;
  logic        wr_en;
  logic [4:0]  rd_addr;
  logic [31:0] wr_data;

  int checks_cnt;
  int errors_cnt;

  reg_file dut (
    .clk     (clk),
    .rst     (rst),
    .ready   (ready),
    .rd_en   (rd_en),
    .rs1_addr(rs1_addr),
    .rs2_addr(rs2_addr),
    .rs1_data(rs1_data),
    .rs2_data(rs2_data),
    .rd_valid(rd_valid),
    .wr_en   (wr_en),
    .rd_addr (rd_addr),
    .wr_data (wr_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_cnt++;
    if (obs !== exp) begin
      errors_cnt++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; outputs are sampled 1 time unit later
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rd_en = 1'b0; wr_en = 1'b0;
    rs1_addr = '0; rs2_addr = '0; rd_addr = '0; wr_data = '0;
  endtask

  task automatic read_pair(input logic [4:0] a1, input logic [4:0] a2,
                           input logic [31:0] e1, input logic [31:0] e2, input string tag);
    rd_en = 1'b1; rs1_addr = a1; rs2_addr = a2;
    step();
    rd_en = 1'b0;
    check_val({tag, "_rs1"}, rs1_data, e1);
    check_val({tag, "_rs2"}, rs2_data, e2);
    check_val({tag, "_vld"}, 32'(rd_valid), 32'd1);
  endtask

  initial begin
    checks_cnt = 0;
    errors_cnt = 0;
    rst = 1'b1;
    idle_inputs();

    // ---- reset values ----
    step(); step();
    check_val("rst_ready", 32'(ready), 32'd0);
    check_val("rst_valid", 32'(rd_valid), 32'd0);
    check_val("rst_rs1", rs1_data, 32'd0);
    check_val("rst_rs2", rs2_data, 32'd0);

    // ---- reset then idle: ready rises on edge 31 ----
    rst = 1'b0;
    for (int e = 1; e <= 31; e++) begin
      step();
      check_val($sformatf("sweep_ready_e%0d", e), 32'(ready), (e == 31) ? 32'd1 : 32'd0);
    end
    $display("sweep done ready=%0d", ready);

    // every register reads zero after the sweep
    for (int i = 1; i <= 31; i++) begin
      read_pair(5'(i), 5'(32 - i), 32'd0, 32'd0, $sformatf("zero_x%0d", i));
    end
    $display("zero scan of x1..x31 done");

    // ---- write then read ----
    wr_en = 1'b1; rd_addr = 5'd5; wr_data = 32'hDEADBEEF;
    step();
    wr_en = 1'b0;
    read_pair(5'd5, 5'd0, 32'hDEADBEEF, 32'd0, "wr_rd_x5");
    $display("write x5, read rs1=%08h rs2=%08h", rs1_data, rs2_data);

    // ---- bypass on both ports ----
    wr_en = 1'b1; rd_addr = 5'd7; wr_data = 32'h12345678;
    read_pair(5'd7, 5'd7, 32'h12345678, 32'h12345678, "bypass_x7");
    wr_en = 1'b0;
    read_pair(5'd7, 5'd5, 32'h12345678, 32'hDEADBEEF, "array_x7");
    $display("bypass x7 rs1=%08h rs2=%08h", rs1_data, rs2_data);

    // ---- independent write and read of different registers ----
    wr_en = 1'b1; rd_addr = 5'd12; wr_data = 32'h00000111;
    read_pair(5'd5, 5'd11, 32'hDEADBEEF, 32'd0, "indep");
    wr_en = 1'b0;
    read_pair(5'd12, 5'd11, 32'h00000111, 32'd0, "indep_after");
    $display("independent rw x12=%08h", rs1_data);

    // ---- x0 protection ----
    wr_en = 1'b1; rd_addr = 5'd0; wr_data = 32'hFFFFFFFF;
    read_pair(5'd0, 5'd5, 32'd0, 32'hDEADBEEF, "x0_wr_rd");
    wr_en = 1'b0;
    read_pair(5'd12, 5'd0, 32'h00000111, 32'd0, "x0_later");
    $display("x0 write dropped rs2=%08h", rs2_data);

    // ---- rd_en low: valid drops, data holds ----
    rs1_addr = 5'd5; rs2_addr = 5'd7;
    step();
    check_val("hold_valid", 32'(rd_valid), 32'd0);
    check_val("hold_rs1", rs1_data, 32'h00000111);
    check_val("hold_rs2", rs2_data, 32'd0);
    $display("idle cycle rd_valid=%0d", rd_valid);

    // ---- mid-operation reset ----
    wr_en = 1'b1; rd_addr = 5'd10; wr_data = 32'h00000055;
    step();
    wr_en = 1'b0;
    read_pair(5'd10, 5'd5, 32'h00000055, 32'hDEADBEEF, "pre_rst_x10");
    #2 rst = 1'b1;
    #1;
    check_val("arst_ready", 32'(ready), 32'd0);
    check_val("arst_valid", 32'(rd_valid), 32'd0);
    check_val("arst_rs1", rs1_data, 32'd0);
    check_val("arst_rs2", rs2_data, 32'd0);
    step();
    rst = 1'b0;
    $display("mid-op reset applied");

    // ---- gating during CLEAR ----
    wr_en = 1'b1; rd_addr = 5'd3; wr_data = 32'hA5A5A5A5;
    rd_en = 1'b1; rs1_addr = 5'd3; rs2_addr = 5'd10;
    for (int e = 1; e <= 31; e++) begin
      step();
      check_val($sformatf("gate_valid_e%0d", e), 32'(rd_valid), 32'd0);
      check_val($sformatf("gate_ready_e%0d", e), 32'(ready), (e == 31) ? 32'd1 : 32'd0);
    end
    idle_inputs();
    check_val("gate_rs1", rs1_data, 32'd0);
    read_pair(5'd3, 5'd10, 32'd0, 32'd0, "post_clr_x3_x10");
    read_pair(5'd5, 5'd7, 32'd0, 32'd0, "post_clr_x5_x7");
    $display("post-reset x3=%08h x10=%08h", rs1_data, rs2_data);

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

  // Bound the run in case the stimulus stalls
  initial begin
    #200000;
    $display("FAIL timeout got=0x%08h exp=0x%08h", 32'(checks_cnt), 32'd0);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/reg_file.md
# reg_file

- Architectural integer register file for the RV32I core.
- Sits directly upstream of the operand registers and feeds them rs1/rs2 values for the instruction in decode.
- Provides two registered read ports and one write port from writeback, with same-cycle write-to-read bypass and x0 hardwired to zero.
- Runs a post-reset clear sweep so every register reads as zero before the core issues.

## Interface

Parameters:
- XLEN, 32, data width
- NREGS, 32, architectural register count (x0..x31)
- AW, 5, register address width, equal to log2(NREGS)

Ports:
- clk  in  1  core clock, rising edge
- rst  in  1  reset; asynchronous, active-high
- ready  out  1  high once the clear sweep is complete; reads and writes are accepted only while high
- rd_en  in  1  read request for rs1_addr/rs2_addr
- rs1_addr  in  AW  source register 1 index
- rs2_addr  in  AW  source register 2 index
- rs1_data  out  XLEN  registered rs1 value
- rs2_data  out  XLEN  registered rs2 value
- rd_valid  out  1  rs1_data/rs2_data carry the result of the previous cycle's accepted read
- wr_en  in  1  writeback write strobe
- rd_addr  in  AW  destination register index
- wr_data  in  XLEN  writeback value

## Operation

- Storage holds NREGS-1 words for x1..x31. x0 is not stored; any read of index 0 returns 0.
- FSM states are CLEAR and RUN.
- **CLEAR**
  - Entered on rst assertion, with clr_ptr=1.
  - Each cycle after rst deasserts, mem[clr_ptr] is written with 0 and clr_ptr increments.
  - After the cycle that clears x31, the FSM moves to RUN.
  - rd_en and wr_en are ignored in this state. No write is performed and rd_valid stays 0.
- **RUN**
  - ready=1.
  - A write is performed when wr_en=1 and rd_addr!=0. A write with rd_addr=0 is dropped silently.
  - A read is accepted when rd_en=1. Next edge: rs1_data and rs2_data are loaded, and rd_valid is set to 1.
  - When rd_en=0, rd_valid is set to 0 and rs1_data/rs2_data hold their previous values.
- **Read-port value selection, per port, in priority order**
  1. Address 0 returns 0.
  2. If wr_en=1, rd_addr==rsN_addr and rd_addr!=0, the port returns wr_data (bypass).
  3. Otherwise the port returns mem[rsN_addr].
- Both ports may read the same register. Both receive an identical value, including the bypass case.
- Simultaneous read and write to different registers are independent.

## Timing

- **Reset values** (all asynchronous on rst): ready=0, rd_valid=0, rs1_data=0, rs2_data=0, state=CLEAR, clr_ptr=1.
- **Clear duration:** NREGS-1 = 31 cycles after the first rising edge with rst low. ready rises on the 31st edge.
- **Read latency:** 1 cycle, from rd_en sampled high to data/rd_valid valid.
- **Write visibility:**
  - A write on edge N is visible to a read sampled on the same edge N through the bypass.
  - It is visible through the array on any later read.
- **rst during RUN or mid-CLEAR:** the sweep restarts from x1, ready drops immediately, and all contents are rezeroed.
- No back-pressure. The consumer must accept every rd_valid pulse.

## Structure

- **Package rv_core_pkg:**
  - Constants XLEN, NREGS, AW, and REG_ZERO = 5'd0.
  - rf_state_t enum {RF_CLEAR, RF_RUN}.
- **Sub-module rf_read_port**, instantiated twice.
  - Purely the port-select logic: x0 zero, bypass compare, array select.
  - Parameterised by XLEN/AW.
- The top level holds the storage array, the clear FSM and pointer, and the output registers.

## Test plan

- **Reset then idle:** release rst and hold rd_en=0 → ready=0 for 30 edges and rises on edge 31. Subsequent reads of x1..x31 all return 0.
- **Write then read:**
  - Write x5=0xDEADBEEF; next cycle read rs1=5, rs2=0 → one cycle later rs1_data=0xDEADBEEF, rs2_data=0, rd_valid=1.
- **Bypass:** in the same cycle, wr_en with x7=0x12345678 and rd_en with rs1=7, rs2=7 → next cycle both outputs are 0x12345678.
- **x0 protection:** write x0=0xFFFFFFFF with a simultaneous read of rs1=0 → rs1_data=0. A later read of x0 also returns 0.
- **Gating during CLEAR:** assert wr_en with x3=0xA5A5A5A5 and rd_en during the sweep → rd_valid stays 0. After ready, x3 reads 0.
- **Mid-operation reset:** write x10=0x55, then pulse rst for 1 cycle → ready=0, rd_valid=0 and outputs=0 asynchronously. After 31 cycles, x10 reads 0.
